// File: rtl/fpu_mult_seq_pkg.sv
// ============================================================================
// Module  : fpu_mult_seq_pkg
// Purpose : Shared FSM encodings, FPU control codes and latency helper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fpu_mult_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [2:0] {
    FPU_ADD   = 3'd0,
    FPU_SUB   = 3'd1,
    FPU_MULT  = 3'd2,
    FPU_MULTU = 3'd3,
    FPU_DIV   = 3'd4
  } fpu_ctrl_e;

  // Cycles from accepted start to the done pulse, inclusive of both ends.
  function automatic int mult_lat(input int width);
    return width + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_mult_seq_if.sv
// ============================================================================
// Module  : fpu_mult_seq_if
// Purpose : Request/response bundle between the control unit and the sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface fpu_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, is_signed, op_a, op_b, flush,
    input  busy, stall, done, result_lo, result_hi
  );

  modport slave (
    input  start, is_signed, op_a, op_b, flush,
    output busy, stall, done, result_lo, result_hi
  );
endinterface

`default_nettype wire

// File: rtl/fpu_mult_seq_mult_step.sv
// ============================================================================
// Module  : mult_step
// Purpose : One radix-2 shift-add step: conditional add into upper half, then >>1.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mult_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [2*WIDTH-1:0] i_acc,
  input  wire logic [WIDTH-1:0]   i_mcand,
  input  wire logic               i_bit,
  output logic      [2*WIDTH-1:0] o_acc_next
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_addend;

  assign w_addend = i_bit ? i_mcand : '0;
  // Carry out of the add lands in the MSB after the shift, so nothing is lost.
  assign w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign o_acc_next = {w_sum, i_acc[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/fpu_mult_seq.sv
// ============================================================================
// Module  : fpu_mult_seq
// Purpose : Multi-cycle signed/unsigned shift-add multiplier sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fpu_mult_seq
  import fpu_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic       clk,
  input wire logic       reset,
  fpu_mult_seq_if.slave  bus
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;

  logic               w_busy;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_busy   = (r_state == S_RUN) || (r_state == S_FIX);
  assign w_accept = bus.start && !bus.flush &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

  // Most-negative input negates to itself, which read unsigned is the right magnitude.
  assign w_mag_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
  assign w_mag_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;

  assign w_prod = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc      (r_acc),
    .i_mcand    (r_mcand),
    .i_bit      (r_mplier[0]),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == C_LAST) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_res_lo <= w_prod[WIDTH-1:0];
            r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.stall     = w_busy | w_accept;
  assign bus.done      = (r_state == S_DONE);
  assign bus.result_lo = r_res_lo;
  assign bus.result_hi = r_res_hi;

endmodule

`default_nettype wire

// File: tb/tb_fpu_mult_seq.sv
// ============================================================================
// Module  : tb_fpu_mult_seq
// Purpose : Self-checking bench: vector table, random ops vs. arithmetic model, corner sequences.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_mult_seq;

  localparam int W   = 32;
  localparam int LAT = 34;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fpu_mult_seq_if #(.WIDTH(W)) bus ();

  fpu_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one op from IDLE/DONE and waits for done; lat counts edges from the sampling edge.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sgn; bus.op_a = a; bus.op_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = {bus.result_hi, bus.result_lo};
  endtask

  vec_t        vecs[7];
  logic [63:0] prod;
  logic [63:0] prev;
  int          lat;
  int          gap;
  bit          seen;

  initial begin
    n_tests = 0; n_fail = 0;
    bus.start = 0; bus.is_signed = 0; bus.op_a = '0; bus.op_b = '0; bus.flush = 0;
    vecs[0] = '{0, 32'd2,          32'd8,          32'h0000_0000, 32'h0000_0010};
    vecs[1] = '{1, 32'd2,          32'hFFFF_FFF8,  32'hFFFF_FFFF, 32'hFFFF_FFF0};
    vecs[2] = '{0, 32'd2,          32'hFFFF_FFF8,  32'h0000_0001, 32'hFFFF_FFF0};
    vecs[3] = '{1, 32'd1000,       32'd2000,       32'h0000_0000, 32'h001E_8480};
    vecs[4] = '{1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{1, 32'h0000_0000,  32'hFFFF_FFFB,  32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {59'd0, bus.busy, bus.done, bus.stall, 2'b00},
        64'd0);
    chk("reset_res", {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, prod, lat);
      chk($sformatf("vec%0d_prod", i), prod, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
    end

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      bit rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
      run_op(rs, ra, rb, prod, lat);
      chk($sformatf("rand%0d", i), prod, ref_mult(rs, ra, rb));
    end

    // Flush mid-run: no done, result held.
    prev = {bus.result_hi, bus.result_lo};
    @(negedge clk);
    bus.start = 1; bus.is_signed = 0; bus.op_a = 32'd77; bus.op_b = 32'd99;
    @(posedge clk); #1 bus.start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk) bus.flush = 1;
    @(posedge clk); #1 bus.flush = 0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    chk("flush_res", {bus.result_hi, bus.result_lo}, prev);
    @(negedge clk);
    bus.start = 1; bus.flush = 1; bus.op_a = 32'd3; bus.op_b = 32'd3;
    #1 chk("flush_start_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 0; bus.flush = 0;
    chk("flush_start_busy", 64'(bus.busy), 64'd0);

    // Back-to-back via start held through DONE.
    @(negedge clk);
    bus.start = 1; bus.is_signed = 1; bus.op_a = 32'd35; bus.op_b = 32'd3;
    #1 chk("b2b_stall", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.op_a = 32'd7; bus.op_b = 32'd7;
    lat = 1;
    while (!bus.done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat1", 64'(lat), 64'(LAT));
    chk("b2b_res1", {bus.result_hi, bus.result_lo}, 64'd105);
    @(posedge clk); #1 bus.start = 0;
    gap = 1;
    while (!bus.done && gap < 60) begin @(posedge clk); #1; gap++; end
    chk("b2b_gap", 64'(gap), 64'(LAT));
    chk("b2b_res2", {bus.result_hi, bus.result_lo}, 64'd49);

    // Start pulse while busy is ignored.
    @(negedge clk);
    bus.start = 1; bus.is_signed = 0; bus.op_a = 32'd5; bus.op_b = 32'd6;
    @(posedge clk); #1 bus.start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk) begin bus.start = 1; bus.op_a = 32'd9; bus.op_b = 32'd9; end
    @(posedge clk); #1 bus.start = 0;
    lat = 6;
    while (!bus.done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", 64'(lat), 64'(LAT));
    chk("ign_res", {bus.result_hi, bus.result_lo}, 64'd30);
    repeat (3) @(posedge clk);
    #1 chk("ign_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Asynchronous reset mid-op.
    @(negedge clk);
    bus.start = 1; bus.is_signed = 1; bus.op_a = 32'hFFFF_FF00; bus.op_b = 32'd3;
    @(posedge clk); #1 bus.start = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_ctl", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
    chk("areset_res", {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    run_op(1'b1, 32'd123, 32'hFFFF_FE38, prod, lat);
    chk("post_reset", prod, ref_mult(1'b1, 32'd123, 32'hFFFF_FE38));
    chk("post_reset_lat", 64'(lat), 64'(LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
